vol_step_ctrl: RTL and testbench

Front-end controller that sequences the 12-bit volume register. Takes raw, bouncing up/down pushbutton inputs and produces clean single-cycle `step_up` / `step_dwn` pulses for the volume register. Adds hold-to-auto-repeat and end-stop clamping using the register's current `volume12` value, so volume never wraps.

---
 rtl/vol_pkg.sv | 32 +++
 rtl/vol_debounce.sv | 40 ++++
 rtl/vol_step_ctrl.sv | 141 ++++++++++++++
 tb/tb_vol_step_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vol_pkg.sv
// Shared constants, state/press-code types and the press-code decode for the volume step controller.
package vol_pkg;

    localparam logic [11:0] STEP       = 12'h040;
    localparam logic [11:0] VOL_NOM    = 12'h800;
    localparam logic [11:0] VOL_UP_LIM = 12'hFC0;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        HOLD,
        REPEAT
    } vol_ctrl_state_t;

    typedef enum logic [1:0] {
        NONE,
        UP,
        DN
    } press_t;

    // Both buttons together cancel out, so only a single pressed button is a command.
    function automatic press_t press_code(input logic up_db, input logic dn_db);
        if (up_db && !dn_db) begin
            return UP;
        end
        if (dn_db && !up_db) begin
            return DN;
        end
        return NONE;
    endfunction

endpackage

// File: rtl/vol_debounce.sv
// Two-flop synchronizer followed by a debouncer: the output level follows the synchronized
// input only after it has disagreed for DEBOUNCE_CYC consecutive cycles.
module vol_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // NOTE: non-blocking assignments keep sync1 -> sync2 a true two-stage pipeline;
    // blocking ones would collapse it into a single flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vol_step_ctrl.sv
// Volume step sequencer: debounced up/down buttons to clamped single-cycle step pulses.
// Auto-repeat (HOLD/REPEAT) is built only when VOL_AUTOREPEAT_EN is defined.
module vol_step_ctrl
    import vol_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int HOLD_CYC     = 25000000,
    parameter int REPEAT_CYC   = 5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_dwn,
    input  logic [11:0] volume12,
    output logic        step_up,
    output logic        step_dwn,
    output logic        busy
);

    // Feedback from the volume register needs one cycle, so repeats closer than 2 apart would clamp on stale data.
    if (REPEAT_CYC < 2 || HOLD_CYC < 1 || DEBOUNCE_CYC < 1) begin : g_param_err
        $error("vol_step_ctrl: need DEBOUNCE_CYC >= 1, HOLD_CYC >= 1, REPEAT_CYC >= 2");
    end

    logic up_db;
    logic dn_db;

    vol_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_up),
        .level (up_db)
    );

    vol_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dn (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_dwn),
        .level (dn_db)
    );

    press_t          press;
    vol_ctrl_state_t state;
    logic            dir;        // 1 = down, 0 = up
    logic            held;
    logic            fire_up;
    logic            fire_dn;

    assign press   = press_code(up_db, dn_db);
    assign held    = (press == (dir ? DN : UP));
    assign fire_up = ~dir & (volume12 < VOL_UP_LIM);
    assign fire_dn =  dir & (volume12 >= STEP);

`ifdef VOL_AUTOREPEAT_EN
    localparam int TMR_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX);

    logic [TMR_W-1:0] timer;
`else
    logic fired;
`endif

    // NOTE: step_* default low every cycle so any branch that fires produces exactly one-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            dir      <= 1'b0;
            step_up  <= 1'b0;
            step_dwn <= 1'b0;
            busy     <= 1'b0;
`ifdef VOL_AUTOREPEAT_EN
            timer    <= '0;
`else
            fired    <= 1'b0;
`endif
        end else begin
            step_up  <= 1'b0;
            step_dwn <= 1'b0;
            case (state)
                IDLE: begin
                    if (press != NONE) begin
                        dir   <= (press == DN);
                        state <= FIRST;
                        busy  <= 1'b1;
                    end
                end
`ifdef VOL_AUTOREPEAT_EN
                FIRST: begin
                    step_up  <= fire_up;
                    step_dwn <= fire_dn;
                    timer    <= '0;
                    state    <= HOLD;
                end
                HOLD: begin
                    if (!held) begin
                        timer <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (timer == TMR_W'(HOLD_CYC - 1)) begin
                        timer <= '0;
                        state <= REPEAT;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                REPEAT: begin
                    if (!held) begin
                        timer <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (timer == TMR_W'(REPEAT_CYC - 1)) begin
                        step_up  <= fire_up;
                        step_dwn <= fire_dn;
                        timer    <= '0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
`else
                // Single-shot build: fire once, then park in FIRST until the press changes.
                FIRST: begin
                    if (!fired) begin
                        step_up  <= fire_up;
                        step_dwn <= fire_dn;
                        fired    <= 1'b1;
                    end else if (!held) begin
                        fired <= 1'b0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vol_step_ctrl.sv
// Scoreboard bench for vol_step_ctrl: a cycle-level reference model schedules expected pulses
// from button/volume history; a monitor matches DUT pulses and busy against it.
module tb_vol_step_ctrl;

    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 5;

`ifdef VOL_AUTOREPEAT_EN
    localparam int HOLD60_PULSES = 8;
`else
    localparam int HOLD60_PULSES = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_up;
    logic        btn_dwn;
    logic [11:0] volume12;
    logic        step_up;
    logic        step_dwn;
    logic        busy;

    vol_step_ctrl #(
        .DEBOUNCE_CYC (DEB),
        .HOLD_CYC     (HOLD),
        .REPEAT_CYC   (REP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (btn_up),
        .btn_dwn  (btn_dwn),
        .volume12 (volume12),
        .step_up  (step_up),
        .step_dwn (step_dwn),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_up     = 0;
    int n_dn     = 0;
    int cyc      = 0;
    bit busy_seen;

    typedef struct {
        int cyc;
        bit dn;
    } exp_t;

    exp_t exp_q[$];
    bit   exp_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Button index 0 = up, 1 = down. Press code: 0 none, 1 up, 2 down.
    bit m_s1[2];
    bit m_s2[2];
    bit m_db[2];
    int m_run[2];
    bit m_active = 1'b0;
    int m_dir    = 0;
    int m_first  = 0;

    function automatic int model_press(input bit up, input bit dn);
        if (up && !dn) return 1;
        if (dn && !up) return 2;
        return 0;
    endfunction

    task automatic model_emit();
        bit dn;
        bit ok;
        dn = (m_dir == 2);
        ok = dn ? (volume12 >= 12'h040) : (volume12 < 12'hFC0);
        if (ok) exp_q.push_back('{cyc: cyc, dn: dn});
    endtask

    task automatic model_step();
        int  prev;
        bit  raw[2];
        cyc++;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_db[i] = 1'b0; m_run[i] = 0;
            end
            m_active = 1'b0;
            exp_busy = 1'b0;
            return;
        end
        // Controller decision uses the debounced levels from before this edge.
        prev = model_press(m_db[0], m_db[1]);
        if (!m_active) begin
            if (prev != 0) begin
                m_active = 1'b1;
                m_dir    = prev;
                m_first  = cyc + 1;
            end
        end else if (cyc == m_first) begin
            model_emit();
        end else if (prev != m_dir) begin
            m_active = 1'b0;
`ifdef VOL_AUTOREPEAT_EN
        end else if (cyc >= m_first + HOLD + REP && (cyc - m_first - HOLD) % REP == 0) begin
            model_emit();
`endif
        end
        exp_busy = m_active;
        raw[0] = btn_up;
        raw[1] = btn_dwn;
        for (int i = 0; i < 2; i++) begin
            if (m_s2[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_db[i]  = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL pulse missing: actual=none required=%s at cycle %0d",
                         exp_q[0].dn ? "step_dwn" : "step_up", exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (busy === 1'b1) busy_seen = 1'b1;
            check("busy", {31'd0, busy}, {31'd0, exp_busy});
            check("step mutex", {31'd0, step_up & step_dwn}, 32'd0);
            if (step_up === 1'b1) n_up++;
            if (step_dwn === 1'b1) n_dn++;
            if (step_up === 1'b1 || step_dwn === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected pulse: actual up=%0b dwn=%0b required=none (cycle %0d)",
                             step_up, step_dwn, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse cycle", cyc, e.cyc);
                    check("pulse dir", {31'd0, step_dwn}, {31'd0, e.dn});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_up(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (step_up === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic settle();
        btn_up  = 1'b0;
        btn_dwn = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    // Hold one button for n cycles at a given volume; return pulse counts seen meanwhile.
    task automatic press_for(input bit dn, input int n, input logic [11:0] vol,
                             output int ups, output int dns, output bit busy_at_end);
        int bu;
        int bd;
        volume12 = vol;
        bu = n_up;
        bd = n_dn;
        if (dn) btn_dwn = 1'b1; else btn_up = 1'b1;
        repeat (n) @(negedge clk);
        busy_at_end = busy;
        settle();
        ups = n_up - bu;
        dns = n_dn - bd;
    endtask

    initial begin
        int  t0;
        int  at;
        int  ups;
        int  dns;
        int  bu;
        int  bd;
        int  dur;
        bit  b_end;

        rst      = 1'b1;
        btn_up   = 1'b0;
        btn_dwn  = 1'b0;
        volume12 = 12'h800;
        repeat (3) @(negedge clk);
        check("reset step_up", {31'd0, step_up}, 32'd0);
        check("reset step_dwn", {31'd0, step_dwn}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Clean short press with latency measurement.
        bu = n_up; bd = n_dn;
        t0 = cyc;
        btn_up = 1'b1;
        wait_up(30, at);
        check("short press latency", at - t0, 8);
        repeat (10 - (cyc - t0)) @(negedge clk);
        settle();
        check("short press up count", n_up - bu, 1);
        check("short press dwn count", n_dn - bd, 0);

        // Bounce rejection on the down button.
        bd = n_dn;
        busy_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            btn_dwn = ~btn_dwn;
            repeat (2) @(negedge clk);
        end
        settle();
        check("bounce dwn count", n_dn - bd, 0);
        check("bounce busy seen", {31'd0, busy_seen}, 32'd0);

        // Held press: auto-repeat (or single shot without the feature).
        press_for(1'b0, 60, 12'h800, ups, dns, b_end);
        check("hold60 up count", ups, HOLD60_PULSES);
        check("hold60 dwn count", dns, 0);

        // End-stop clamps and the values just inside them.
        press_for(1'b0, 60, 12'hFC0, ups, dns, b_end);
        check("clamp top up count", ups, 0);
        check("clamp top busy held", {31'd0, b_end}, 32'd1);
        press_for(1'b1, 60, 12'h000, ups, dns, b_end);
        check("clamp bottom dwn count", dns, 0);
        check("clamp bottom busy held", {31'd0, b_end}, 32'd1);
        press_for(1'b0, 10, 12'hFBF, ups, dns, b_end);
        check("below top up count", ups, 1);
        press_for(1'b1, 10, 12'h040, ups, dns, b_end);
        check("at STEP dwn count", dns, 1);
        press_for(1'b1, 10, 12'h03F, ups, dns, b_end);
        check("below STEP dwn count", dns, 0);

        // Simultaneous buttons.
        volume12 = 12'h800;
        bu = n_up; bd = n_dn;
        busy_seen = 1'b0;
        btn_up  = 1'b1;
        btn_dwn = 1'b1;
        repeat (30) @(negedge clk);
        settle();
        check("both pressed pulses", (n_up - bu) + (n_dn - bd), 0);
        check("both pressed busy seen", {31'd0, busy_seen}, 32'd0);

        // Down added mid-HOLD cancels the up press.
        bu = n_up; bd = n_dn;
        btn_up = 1'b1;
        repeat (23) @(negedge clk);
        btn_dwn = 1'b1;
        repeat (40) @(negedge clk);
        check("both held busy", {31'd0, busy}, 32'd0);
        settle();
        check("mid-hold cancel up count", n_up - bu, 1);
        check("mid-hold cancel dwn count", n_dn - bd, 0);

        // Reset in the middle of a held press.
        btn_up = 1'b1;
        repeat (35) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        t0 = cyc;
        check("mid reset step_up", {31'd0, step_up}, 32'd0);
        check("mid reset step_dwn", {31'd0, step_dwn}, 32'd0);
        check("mid reset busy", {31'd0, busy}, 32'd0);
        wait_up(20, at);
        check("post reset latency", at - t0, 8);
        settle();

        // Randomized segments with occasional resets and boundary volumes.
        for (int s = 0; s < 150; s++) begin
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            btn_up  = 1'($urandom_range(0, 1));
            btn_dwn = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       volume12 = 12'h000;
                1:       volume12 = 12'h03F;
                2:       volume12 = 12'h040;
                3:       volume12 = 12'hFBF;
                4:       volume12 = 12'hFC0;
                5:       volume12 = 12'hFFF;
                default: volume12 = 12'($urandom_range(0, 4095));
            endcase
            dur = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(8, 60));
            repeat (dur) @(negedge clk);
        end
        settle();
        repeat (5) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
